// File: rtl/tohost_exit_device_pkg.sv
// Shared definitions for the tohost exit device: register offsets, FSM states, exit codes.
package tohost_exit_device_pkg;

  localparam logic [1:0] TOHOST_OFS   = 2'd0;
  localparam logic [1:0] CYCLE_LO_OFS = 2'd1;
  localparam logic [1:0] CYCLE_HI_OFS = 2'd2;
  localparam logic [1:0] CONSOLE_OFS  = 2'd3;

  localparam int unsigned CNT_W     = 64;
  localparam logic [31:0] PASS_CODE = 32'd1;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

endpackage

// File: rtl/tohost_exit_device_cycle_counter64.sv
// Free-running 64-bit cycle counter with a high-word snapshot taken on CYCLE_LO reads.
module cycle_counter64
  import tohost_exit_device_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             snap_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [31:0]      hi_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;

  // Snapshot uses the pre-increment value so LO and HI come from the same count.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    hi_d  = snap_i ? cnt_q[63:32] : hi_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      hi_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
    end
  end

  assign cnt_o = cnt_q;
  assign hi_o  = hi_q;

endmodule

// File: rtl/tohost_exit_device.sv
// Memory-mapped exit/console/cycle-counter responder for the simulation top.
// Optional watchdog exit enabled by defining EXIT_WATCHDOG_EN.
module tohost_exit_device
  import tohost_exit_device_pkg::*;
#(
  parameter int unsigned WATCHDOG_CYCLES = 100000,
  parameter logic [31:0] FAIL_CODE       = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wen,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        char_valid,
  output logic [7:0]  char_data,
  output logic        exit,
  output logic [31:0] gp
);

  state_e           state_q, state_d;
  logic [31:0]      tohost_q, tohost_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      gp_q, gp_d;
  logic             exit_q, exit_d;
  logic             chv_q, chv_d;
  logic [7:0]       chd_q, chd_d;
  logic             snap;
  logic             accept;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      cnt_hi;

  cycle_counter64 u_cnt (
    .clk    (clk),
    .rst    (rst),
    .snap_i (snap),
    .cnt_o  (cnt),
    .hi_o   (cnt_hi)
  );

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d  = state_q;
    tohost_d = tohost_q;
    rdata_d  = '0;
    gp_d     = gp_q;
    exit_d   = exit_q;
    chv_d    = 1'b0;
    chd_d    = chd_q;
    snap     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RESP;
          case (req_addr[3:2])
            TOHOST_OFS: begin
              if (req_wen) begin
                tohost_d = req_wdata;
                if (req_wdata[0] && !exit_q) begin
                  exit_d = 1'b1;
                  gp_d   = req_wdata;
                end
              end else begin
                rdata_d = tohost_q;
              end
            end
            CYCLE_LO_OFS: begin
              if (!req_wen) begin
                rdata_d = cnt[31:0];
                snap    = 1'b1;
              end
            end
            CYCLE_HI_OFS: begin
              if (!req_wen) rdata_d = cnt_hi;
            end
            default: begin
              if (req_wen) begin
                chv_d = 1'b1;
                chd_d = req_wdata[7:0];
              end
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef EXIT_WATCHDOG_EN
    // A TOHOST exit accepted this same cycle already set exit_d and keeps its code.
    if (cnt == CNT_W'(WATCHDOG_CYCLES) && !exit_d) begin
      exit_d = 1'b1;
      gp_d   = FAIL_CODE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tohost_q <= '0;
      rdata_q  <= '0;
      gp_q     <= '0;
      exit_q   <= 1'b0;
      chv_q    <= 1'b0;
      chd_q    <= '0;
    end else begin
      state_q  <= state_d;
      tohost_q <= tohost_d;
      rdata_q  <= rdata_d;
      gp_q     <= gp_d;
      exit_q   <= exit_d;
      chv_q    <= chv_d;
      chd_q    <= chd_d;
    end
  end

  // Pulses are masked while reset is asserted so a response caught by reset is dropped.
  assign resp_valid = (state_q == RESP) && !rst;
  assign resp_rdata = rdata_q;
  assign char_valid = chv_q && !rst;
  assign char_data  = chd_q;
  assign exit       = exit_q;
  assign gp         = gp_q;

`ifdef EXIT_WATCHDOG_EN
  logic unused_bits;
  assign unused_bits = ^{req_addr[31:4], req_addr[1:0]};
`else
  logic unused_bits;
  assign unused_bits = ^{req_addr[31:4], req_addr[1:0], WATCHDOG_CYCLES, FAIL_CODE};
`endif

endmodule
